exp_mult_pipe: RTL and testbench

Parametrised, pipelined exponent unit for the FP multiplier datapath. Computes the biased result exponent Ea + Eb + norm_inc - BIAS over a 2-stage valid/ready pipeline with backpressure. Per-result overflow/underflow flags travel with the data; sticky flags accumulate them. Sits between operand unpacking and the rounding/packing stage; replaces the single-register exponent path for both single (EW=8) and double (EW=11) precision.

---
 rtl/exp_mult_pipe.sv | 120 ++++++++++++
 tb/tb_exp_mult_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_mult_pipe.sv
// exp_mult_pipe: 2-stage biased exponent add/unbias with valid/ready flow.
// Define EXP_SAT_EN to clamp exp_o on overflow (max finite) / underflow (0).
module exp_mult_pipe #(
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [EW-1:0] exp_a_i,
  input  logic [EW-1:0] exp_b_i,
  input  logic          norm_inc_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [EW-1:0] exp_o,
  output logic          ovf_o,
  output logic          unf_o,
  input  logic          clr_flags_i,
  output logic          ovf_sticky_o,
  output logic          unf_sticky_o
);

  localparam int W    = EW + 2;
  localparam int BIAS = 2**(EW-1) - 1;
  localparam logic [W-1:0] BIAS_W = W'(BIAS);
  localparam logic signed [W-1:0] TOP_W = W'(2**EW - 1);

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_sum;
  logic          r_s2_valid;
  logic [EW-1:0] r_exp;
  logic          r_ovf;
  logic          r_unf;
  logic          r_ovf_st;
  logic          r_unf_st;

  logic                w_s1_adv;
  logic                w_s2_adv;
  logic                w_in_hs;
  logic                w_out_hs;
  logic [W-1:0]        w_sum;
  logic signed [W-1:0] w_res;
  logic                w_ovf;
  logic                w_unf;
  logic [EW-1:0]       w_exp;

  assign w_s2_adv = !r_s2_valid || out_ready_i;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_in_hs  = in_valid_i && w_s1_adv;
  assign w_out_hs = r_s2_valid && out_ready_i;

  assign w_sum = {2'b00, exp_a_i}
               + {2'b00, exp_b_i}
               + {{(W-1){1'b0}}, norm_inc_i};

  // Sum is at most 2**(EW+1)-1, so the sign bit of res is always free.
  assign w_res = $signed(r_s1_sum - BIAS_W);
  assign w_ovf = w_res >= TOP_W;
  assign w_unf = w_res[W-1] || (w_res == '0);

`ifdef EXP_SAT_EN
  always_comb begin
    w_exp = w_res[EW-1:0];
    if (w_ovf)
      w_exp = {{(EW-1){1'b1}}, 1'b0};
    else if (w_unf)
      w_exp = '0;
  end
`else
  assign w_exp = w_res[EW-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
    end else begin
      if (w_s1_adv)
        r_s1_valid <= in_valid_i;
      if (w_in_hs)
        r_s1_sum <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_exp      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_exp <= w_exp;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
      end
    end
  end

  // A flagging handshake overrides a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf_st <= 1'b0;
      r_unf_st <= 1'b0;
    end else begin
      r_ovf_st <= (r_ovf_st && !clr_flags_i) || (w_out_hs && r_ovf);
      r_unf_st <= (r_unf_st && !clr_flags_i) || (w_out_hs && r_unf);
    end
  end

  assign in_ready_o   = w_s1_adv;
  assign out_valid_o  = r_s2_valid;
  assign exp_o        = r_exp;
  assign ovf_o        = r_ovf;
  assign unf_o        = r_unf;
  assign ovf_sticky_o = r_ovf_st;
  assign unf_sticky_o = r_unf_st;

endmodule

// File: tb/tb_exp_mult_pipe.sv
// tb_exp_mult_pipe: directed vectors on EW=8 and EW=11 instances,
// checked against an arithmetic model and hand-computed literals.
module tb_exp_mult_pipe;

  typedef struct packed {
    logic        ovf;
    logic        unf;
    logic [15:0] e;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       v8 = 1'b0, or8 = 1'b1, n8 = 1'b0, clr8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       r8, ov8, ovf8, unf8, os8, us8;
  logic [7:0] e8;

  logic        v11 = 1'b0, or11 = 1'b1, n11 = 1'b0, clr11 = 1'b0;
  logic [10:0] a11 = '0, b11 = '0;
  logic        r11, ov11, ovf11, unf11, os11, us11;
  logic [10:0] e11;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  res_t q[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  logic hold_v = 1'b0;
  logic [9:0] hold = '0;

  exp_mult_pipe #(.EW(8)) u_d8 (
    .clk(clk), .rst(rst),
    .in_valid_i(v8), .in_ready_o(r8),
    .exp_a_i(a8), .exp_b_i(b8), .norm_inc_i(n8),
    .out_valid_o(ov8), .out_ready_i(or8),
    .exp_o(e8), .ovf_o(ovf8), .unf_o(unf8),
    .clr_flags_i(clr8),
    .ovf_sticky_o(os8), .unf_sticky_o(us8)
  );

  exp_mult_pipe #(.EW(11)) u_d11 (
    .clk(clk), .rst(rst),
    .in_valid_i(v11), .in_ready_o(r11),
    .exp_a_i(a11), .exp_b_i(b11), .norm_inc_i(n11),
    .out_valid_o(ov11), .out_ready_i(or11),
    .exp_o(e11), .ovf_o(ovf11), .unf_o(unf11),
    .clr_flags_i(clr11),
    .ovf_sticky_o(os11), .unf_sticky_o(us11)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic res_t model(input int a, input int b,
                                 input int n, input int ew);
    res_t r;
    int top;
    int s;
    top = (1 << ew) - 1;
    s = a + b + n - ((1 << (ew - 1)) - 1);
    r.ovf = (s >= top);
    r.unf = (s <= 0);
`ifdef EXP_SAT_EN
    r.e = r.ovf ? 16'(top - 1) : (r.unf ? 16'd0 : 16'(s));
`else
    r.e = 16'(s & top);
`endif
    return r;
  endfunction

  // Scoreboard for the EW=8 instance: order, data, stall hold, stickies.
  initial begin
    res_t f;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          chk("stall_hold", 32'({e8, ovf8, unf8}), 32'(hold));
        if (ov8 && or8) begin
          chk("pop_nonempty", 32'(q.size() == 0), 32'd0);
          if (q.size() > 0) begin
            f = q.pop_front();
            chk("out_exp", 32'(e8), 32'(f.e[7:0]));
            chk("out_ovf", 32'(ovf8), 32'(f.ovf));
            chk("out_unf", 32'(unf8), 32'(f.unf));
            m_ovf = (m_ovf && !clr8) || f.ovf;
            m_unf = (m_unf && !clr8) || f.unf;
            n_out++;
          end
        end else if (clr8) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (v8 && r8)
          q.push_back(model(int'(a8), int'(b8), int'(n8), 8));
        hold_v = ov8 && !or8;
        hold = {e8, ovf8, unf8};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ovf_sticky", 32'(os8), 32'(m_ovf));
        chk("unf_sticky", 32'(us8), 32'(m_unf));
        chk("valid_has_item", 32'(ov8 && q.size() == 0), 32'd0);
      end
    end
  end

  task automatic one8(input int a, input int b, input int n,
                      input int ee, input int eo, input int eu);
    @(negedge clk);
    v8 = 1'b1; a8 = 8'(a); b8 = 8'(b); n8 = 1'(n); or8 = 1'b1;
    #1 chk("d8_in_ready", 32'(r8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    chk("d8_lat_early", 32'(ov8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("d8_lat_valid", 32'(ov8), 32'd1);
    chk("d8_lit_exp", 32'(e8), 32'(ee));
    chk("d8_lit_ovf", 32'(ovf8), 32'(eo));
    chk("d8_lit_unf", 32'(unf8), 32'(eu));
  endtask

  task automatic one11(input int a, input int b,
                       input int ee, input int eo, input int eu);
    res_t m;
    m = model(a, b, 0, 11);
    @(negedge clk);
    v11 = 1'b1; a11 = 11'(a); b11 = 11'(b); n11 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v11 = 1'b0;
    chk("d11_lat_early", 32'(ov11), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("d11_lat_valid", 32'(ov11), 32'd1);
    chk("d11_lit_exp", 32'(e11), 32'(ee));
    chk("d11_lit_ovf", 32'(ovf11), 32'(eo));
    chk("d11_lit_unf", 32'(unf11), 32'(eu));
    chk("d11_mdl_exp", 32'(e11), 32'(m.e[10:0]));
  endtask

  task automatic stream(input int n, input int sa[8], input int sb[8],
                        input logic [31:0] rpat, output int lowseen);
    int idx;
    int t;
    int start;
    logic acc;
    idx = 0;
    t = 0;
    lowseen = 0;
    start = n_out;
    while ((idx < n || n_out < start + n) && t < 200) begin
      @(negedge clk);
      or8 = rpat[t % 32];
      v8 = (idx < n);
      a8 = 8'(sa[idx % 8]);
      b8 = 8'(sb[idx % 8]);
      n8 = 1'b0;
      #1;
      acc = v8 && r8;
      if (v8 && !r8)
        lowseen++;
      @(posedge clk);
      #1;
      if (acc)
        idx++;
      t++;
    end
    chk("stream_timeout", 32'(t >= 200), 32'd0);
    chk("stream_count", 32'(n_out - start), 32'(n));
    @(negedge clk);
    v8 = 1'b0;
    or8 = 1'b1;
  endtask

  initial begin
    int low;
    int sa[8];
    int sb[8];
    res_t m;

    #1;
    chk("rst_valid", 32'(ov8), 32'd0);
    chk("rst_exp", 32'(e8), 32'd0);
    chk("rst_flags", 32'({ovf8, unf8, os8, us8}), 32'd0);
    chk("rst_ready", 32'(r8), 32'd1);
    #20;
    @(negedge clk);
    rst = 1'b1;

    m = model(130, 127, 0, 8);
    chk("model_pin_130", 32'(m.e), 32'd130);

    one8(130, 127, 0, 130, 0, 0);
    one8(127, 127, 1, 128, 0, 0);
    one8(191, 190, 0, 254, 0, 0);
`ifdef EXP_SAT_EN
    one8(191, 191, 0, 254, 1, 0);
    one8(50, 50, 0, 0, 0, 1);
`else
    one8(191, 191, 0, 255, 1, 0);
    one8(50, 50, 0, 229, 0, 1);
`endif
    one8(64, 63, 0, 0, 0, 1);
    one8(64, 64, 0, 1, 0, 0);

    // clear pulsed alone
    @(negedge clk);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("clr_ovf_st", 32'(os8), 32'd0);
    chk("clr_unf_st", 32'(us8), 32'd0);

    one8(191, 191, 0, 32'(model(191, 191, 0, 8).e), 1, 0);
    @(negedge clk);
    chk("set_ovf_st", 32'(os8), 32'd1);
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("clr2_ovf_st", 32'(os8), 32'd0);

    // clear coincident with a flagging handshake
    @(negedge clk);
    v8 = 1'b1; a8 = 8'd191; b8 = 8'd191; or8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    chk("coin_valid", 32'(ov8), 32'd1);
    or8 = 1'b1;
    clr8 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    chk("coin_ovf_st", 32'(os8), 32'd1);

    sa = '{130, 191, 50, 64, 127, 0, 255, 100};
    sb = '{127, 191, 50, 63, 127, 0, 255, 27};
    stream(4, sa, sb, 32'hFFFF_FFE3, low);
    chk("bp_ready_low", 32'(low), 32'd3);
    stream(8, sa, sb, 32'hAAAA_AAAA, low);
    stream(6, sa, sb, 32'hF0F0_3C3C, low);

    one11(1023, 1024, 1024, 0, 0);
`ifdef EXP_SAT_EN
    one11(2000, 2000, 2046, 1, 0);
`else
    one11(2000, 2000, 929, 1, 0);
`endif

    // reset in the middle of traffic
    @(negedge clk);
    v8 = 1'b1; a8 = 8'd100; b8 = 8'd100; or8 = 1'b0;
    v11 = 1'b1; a11 = 11'd500; b11 = 11'd600; or11 = 1'b0;
    @(negedge clk);
    a8 = 8'd101;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(ov8), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_v8", 32'(ov8), 32'd0);
    chk("mid_rst_v11", 32'(ov11), 32'd0);
    chk("mid_rst_st8", 32'({os8, us8}), 32'd0);
    chk("mid_rst_st11", 32'({os11, us11}), 32'd0);
    v8 = 1'b0;
    v11 = 1'b0;
    or8 = 1'b1;
    or11 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_r8", 32'(r8), 32'd1);
    chk("post_rst_r11", 32'(r11), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({ov8, ov11}), 32'd0);
    end

    one8(130, 127, 0, 130, 0, 0);
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
